// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle control sequencer for the 8-bit CPU.
// Walks FETCH/DECODE/EXEC/MEM, drives every datapath strobe and owns the
// req/ack handshake to memory. Outputs are combinational from state + IR.
//
// Memory handshake (valid/ready style): mem_req_o is the valid, mem_ack_i is
// the ready. The request and mem_we_o stay asserted and unchanged from the
// first requesting cycle until the cycle in which mem_ack_i is sampled high;
// that cycle completes the transfer. mem_ack_i in any other state is ignored.
module cpu_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic [7:0] instr_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_sel_o,
  output logic       ir_load_o,
  output logic       pc_inc_o,
  output logic       pc_load_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] acc_src_o,
  output logic       acc_we_o,
  output logic       reg_we_o,
  output logic       out_we_o,
  output logic       halted_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // Last waiting cycle: if no ack arrives here, the next state is FAULT.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            run_armed_q;   // run_i seen low while halted
  logic [3:0]      opcode;
  logic            is_ld, is_st, to_last;
  logic            unused_operand;

  assign opcode  = instr_i[7:4];
  assign is_ld   = (opcode == 4'h7);
  assign is_st   = (opcode == 4'h8);
  assign to_last = (to_cnt_q == TO_LAST);
  // The operand field is consumed by the datapath, not by the sequencer.
  assign unused_operand = ^instr_i[3:0];

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Wait counter: cleared on every state change, counts while waiting for ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
    end else if (state_d != state_q) begin
      to_cnt_q <= '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // HALT resume arming: a low run_i must be seen before a high one resumes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  run_armed_q <= 1'b0;
    else if (state_q != S_HALT) run_armed_q <= 1'b0;
    else if (!run_i)            run_armed_q <= 1'b1;
  end

  // Next-state logic; an ack in the last waiting cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run_i) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack_i)    state_d = S_DECODE;
        else if (to_last) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (is_ld || is_st)      state_d = S_MEM;
        else if (opcode == 4'hF) state_d = S_HALT;
        else                     state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_FETCH;
      S_MEM: begin
        if (mem_ack_i)    state_d = S_FETCH;
        else if (to_last) state_d = S_FAULT;
      end
      S_HALT:   if (run_armed_q && run_i) state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from current state, instruction, zero flag and ack.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_load_o  = 1'b0;
    pc_inc_o   = 1'b0;
    pc_load_o  = 1'b0;
    alu_op_o   = 3'd0;
    acc_src_o  = 2'd0;
    acc_we_o   = 1'b0;
    reg_we_o   = 1'b0;
    out_we_o   = 1'b0;
    state_o    = state_q;
    halted_o   = (state_q == S_HALT) || (state_q == S_FAULT);
    fault_o    = (state_q == S_FAULT);
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_load_o = 1'b1;
          pc_inc_o  = 1'b1;
        end
      end
      S_EXEC: begin
        case (opcode)
          4'h1: begin
            acc_we_o  = 1'b1;
            acc_src_o = 2'd1;
          end
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            acc_we_o = 1'b1;
            alu_op_o = 3'(opcode - 4'd2);
          end
          4'h9: begin
            acc_we_o  = 1'b1;
            acc_src_o = 2'd3;
          end
          4'hA: out_we_o  = 1'b1;
          4'hB: pc_load_o = 1'b1;
          4'hC: pc_load_o = zero_i;
          4'hD: reg_we_o  = 1'b1;
          // MOVR: ALU ADD with the datapath zeroing input A.
          4'hE: acc_we_o  = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = is_st;
        if (mem_ack_i && is_ld) begin
          acc_we_o  = 1'b1;
          acc_src_o = 2'd2;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: vector table of instructions plus hand sequences for reset,
// timeouts and HALT resume; per-cycle expected outputs go through exp_q.
module tb_cpu_ctrl;

  localparam int W = 19;

  logic       clk_i = 1'b0;
  logic       rst_i, run_i, zero_i, mem_ack_i;
  logic [7:0] instr_i;
  logic       mem_req_o, mem_we_o, addr_sel_o, ir_load_o, pc_inc_o, pc_load_o;
  logic [2:0] alu_op_o;
  logic [1:0] acc_src_o;
  logic       acc_we_o, reg_we_o, out_we_o, halted_o, fault_o;
  logic [2:0] state_o;

  cpu_ctrl #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .instr_i(instr_i),
    .zero_i(zero_i), .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .addr_sel_o(addr_sel_o), .ir_load_o(ir_load_o),
    .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o), .alu_op_o(alu_op_o),
    .acc_src_o(acc_src_o), .acc_we_o(acc_we_o), .reg_we_o(reg_we_o),
    .out_we_o(out_we_o), .halted_o(halted_o), .fault_o(fault_o),
    .state_o(state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  // Observed bundle: {state, req, we, asel, irl, pci, pcl, alu_op, src, awe, rwe, owe, halted, fault}
  logic [W-1:0] act;
  assign act = {state_o, mem_req_o, mem_we_o, addr_sel_o, ir_load_o, pc_inc_o,
                pc_load_o, alu_op_o, acc_src_o, acc_we_o, reg_we_o, out_we_o,
                halted_o, fault_o};

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  // hs = {req, we, asel, ir_load, pc_inc, pc_load}; wes = {acc_we, reg_we, out_we}
  function automatic logic [W-1:0] pk(input logic [2:0] st, input logic [5:0] hs,
                                      input logic [2:0] aop, input logic [1:0] src,
                                      input logic [2:0] wes);
    logic hlt, flt;
    hlt = (st == 3'd5) || (st == 3'd6);
    flt = (st == 3'd6);
    return {st, hs, aop, src, wes, hlt, flt};
  endfunction

  function automatic logic [W-1:0] r_idle();  return pk(3'd0, 6'b000000, 3'd0, 2'd0, 3'b000); endfunction
  function automatic logic [W-1:0] r_fwait(); return pk(3'd1, 6'b100000, 3'd0, 2'd0, 3'b000); endfunction
  function automatic logic [W-1:0] r_fack();  return pk(3'd1, 6'b100110, 3'd0, 2'd0, 3'b000); endfunction
  function automatic logic [W-1:0] r_dec();   return pk(3'd2, 6'b000000, 3'd0, 2'd0, 3'b000); endfunction
  function automatic logic [W-1:0] r_halt();  return pk(3'd5, 6'b000000, 3'd0, 2'd0, 3'b000); endfunction
  function automatic logic [W-1:0] r_fault(); return pk(3'd6, 6'b000000, 3'd0, 2'd0, 3'b000); endfunction

  // Drive one cycle: apply ack, compare at the falling edge, step to posedge+1.
  task automatic cycle(input logic ack, input string nm);
    logic [W-1:0] e;
    mem_ack_i = ack;
    @(negedge clk_i);
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, actual %h", nm, act);
    end else begin
      e = exp_q.pop_front();
      if (act === e) passes++;
      else $display("FAIL %s: actual %h expected %h (t=%0t)", nm, act, e, $time);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cycle(input logic [W-1:0] e, input logic ack, input string nm);
    exp_q.push_back(e);
    cycle(ack, nm);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic       zero;
    int         fdly;    // FETCH cycles without ack
    logic       is_mem;
    int         mdly;    // MEM cycles without ack
    logic [5:0] hs;      // EXEC / MEM-ack handshake+pc strobes
    logic [2:0] aop;
    logic [1:0] src;
    logic [2:0] wes;
  } vec_t;

  function automatic vec_t mkv(input logic [7:0] i, input logic z, input int fd,
                               input logic m, input int md, input logic [5:0] hs,
                               input logic [2:0] aop, input logic [1:0] src,
                               input logic [2:0] wes);
    vec_t v;
    v.instr = i; v.zero = z; v.fdly = fd; v.is_mem = m; v.mdly = md;
    v.hs = hs; v.aop = aop; v.src = src; v.wes = wes;
    return v;
  endfunction

  // Run one instruction starting in FETCH; ends at the next FETCH.
  task automatic run_vec(input vec_t v, input string nm);
    instr_i = v.instr;
    zero_i  = v.zero;
    for (int i = 0; i < v.fdly; i++) exp_q.push_back(r_fwait());
    exp_q.push_back(r_fack());
    exp_q.push_back(r_dec());
    if (v.is_mem) begin
      for (int i = 0; i < v.mdly; i++) exp_q.push_back(pk(3'd4, v.hs, 3'd0, 2'd0, 3'b000));
      exp_q.push_back(pk(3'd4, v.hs, v.aop, v.src, v.wes));
    end else begin
      exp_q.push_back(pk(3'd3, v.hs, v.aop, v.src, v.wes));
    end
    for (int i = 0; i < v.fdly; i++) cycle(1'b0, {nm, "_fetch_wait"});
    cycle(1'b1, {nm, "_fetch_ack"});
    cycle(1'($urandom_range(0, 1)), {nm, "_decode"});
    if (v.is_mem) begin
      for (int i = 0; i < v.mdly; i++) cycle(1'b0, {nm, "_mem_wait"});
      cycle(1'b1, {nm, "_mem_ack"});
    end else begin
      cycle(1'($urandom_range(0, 1)), {nm, "_exec"});
    end
  endtask

  // Reset with run_i high, release, leave the DUT about to enter FETCH.
  task automatic reset_and_start(input string nm);
    rst_i = 1'b1;
    run_i = 1'b1;
    push_cycle(r_idle(), 1'b0, {nm, "_reset_hold"});
    rst_i = 1'b0;
    push_cycle(r_idle(), 1'b0, {nm, "_reset_release"});
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = mkv(8'h15, 1'b0, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd1, 3'b100); // LDI 5
    vecs[1]  = mkv(8'h22, 1'b0, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd0, 3'b100); // ADD r2
    vecs[2]  = mkv(8'hA0, 1'b1, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd0, 3'b001); // OUT
    vecs[3]  = mkv(8'h33, 1'b0, 2,  1'b0, 0,  6'b000000, 3'd1, 2'd0, 3'b100); // SUB
    vecs[4]  = mkv(8'h41, 1'b1, 0,  1'b0, 0,  6'b000000, 3'd2, 2'd0, 3'b100); // AND
    vecs[5]  = mkv(8'h5F, 1'b0, 1,  1'b0, 0,  6'b000000, 3'd3, 2'd0, 3'b100); // OR
    vecs[6]  = mkv(8'h67, 1'b0, 0,  1'b0, 0,  6'b000000, 3'd4, 2'd0, 3'b100); // XOR
    vecs[7]  = mkv(8'h00, 1'b1, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd0, 3'b000); // NOP
    vecs[8]  = mkv(8'h90, 1'b0, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd3, 3'b100); // IN
    vecs[9]  = mkv(8'hB4, 1'b0, 0,  1'b0, 0,  6'b000001, 3'd0, 2'd0, 3'b000); // JMP
    vecs[10] = mkv(8'hC9, 1'b0, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd0, 3'b000); // JZ not taken
    vecs[11] = mkv(8'hC9, 1'b1, 0,  1'b0, 0,  6'b000001, 3'd0, 2'd0, 3'b000); // JZ taken
    vecs[12] = mkv(8'hD2, 1'b0, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd0, 3'b010); // MOV
    vecs[13] = mkv(8'hE5, 1'b1, 0,  1'b0, 0,  6'b000000, 3'd0, 2'd0, 3'b100); // MOVR
    vecs[14] = mkv(8'h73, 1'b0, 0,  1'b1, 4,  6'b101000, 3'd0, 2'd2, 3'b100); // LD r3, 4 waits
    vecs[15] = mkv(8'h81, 1'b0, 0,  1'b1, 2,  6'b111000, 3'd0, 2'd0, 3'b000); // ST r1, 2 waits
    vecs[16] = mkv(8'h70, 1'b0, 14, 1'b1, 14, 6'b101000, 3'd0, 2'd2, 3'b100); // ack on 15th cycle
    vecs[17] = mkv(8'h12, 1'b0, 14, 1'b0, 0,  6'b000000, 3'd0, 2'd1, 3'b100); // LDI, late fetch ack

    rst_i = 1'b1; run_i = 1'b0; instr_i = 8'h00; zero_i = 1'b0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    push_cycle(r_idle(), 1'b0, "reset_state");
    rst_i = 1'b0;
    push_cycle(r_idle(), 1'b1, "idle_no_run");
    push_cycle(r_idle(), 1'b0, "idle_no_run2");
    run_i = 1'b1;
    push_cycle(r_idle(), 1'b0, "idle_run_seen");

    for (int k = 0; k < 18; k++) run_vec(vecs[k], $sformatf("vec%0d_%h", k, vecs[k].instr));

    // Async reset in the middle of a FETCH request.
    push_cycle(r_fwait(), 1'b0, "fetch_before_reset");
    #2 rst_i = 1'b1;
    push_cycle(r_idle(), 1'b1, "reset_mid_fetch");
    rst_i = 1'b0;
    push_cycle(r_idle(), 1'b0, "reset_mid_release");

    // FETCH timeout: 15 cycles without ack, FAULT is sticky.
    for (int i = 0; i < 15; i++) push_cycle(r_fwait(), 1'b0, "fetch_to_wait");
    for (int i = 0; i < 4; i++) begin
      run_i = 1'(i & 1);
      push_cycle(r_fault(), 1'b1, "fetch_fault_sticky");
    end
    reset_and_start("after_fetch_fault");

    // MEM timeout on an LD.
    instr_i = 8'h75;
    push_cycle(r_fack(), 1'b1, "ldto_fetch_ack");
    push_cycle(r_dec(), 1'b0, "ldto_decode");
    for (int i = 0; i < 15; i++) push_cycle(pk(3'd4, 6'b101000, 3'd0, 2'd0, 3'b000), 1'b0, "ldto_mem_wait");
    push_cycle(r_fault(), 1'b1, "mem_fault");
    push_cycle(r_fault(), 1'b0, "mem_fault_sticky");
    reset_and_start("after_mem_fault");

    // HLT: two cycles to reach HALT, resume only after run_i falls and rises.
    instr_i = 8'hF0;
    push_cycle(r_fack(), 1'b1, "hlt_fetch_ack");
    push_cycle(r_dec(), 1'b0, "hlt_decode");
    for (int i = 0; i < 3; i++) push_cycle(r_halt(), 1'b1, "halt_run_high");
    run_i = 1'b0;
    for (int i = 0; i < 2; i++) push_cycle(r_halt(), 1'b0, "halt_run_low");
    run_i = 1'b1;
    push_cycle(r_halt(), 1'b0, "halt_run_rise");
    push_cycle(r_fack(), 1'b1, "halt_resume_fetch");

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog: the run is cycle-bounded, this only guards against a stuck bench.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", passes, checks);
    $fatal(1);
  end

endmodule
